// File: rtl/tl_tx_credit_ctrl.sv
// Transmit-side flow-control credit controller: tracks partner credit limits and consumed credits
// for the six TL pools. Optional build macro TL_CREDIT_INF_EN treats an InitFC value of 0 as infinite.
module tl_tx_credit_ctrl #(
  parameter int unsigned HDR_W          = 8,
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned MAX_PAYLOAD_CR = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_up_i,
  input  logic              fc_valid_i,
  input  logic              fc_init_i,
  input  logic [1:0]        fc_type_i,
  input  logic [HDR_W-1:0]  fc_hdr_i,
  input  logic [DATA_W-1:0] fc_data_i,
  input  logic              ph_consume_v_i,
  input  logic              nph_consume_v_i,
  input  logic              cplh_consume_v_i,
  input  logic [HDR_W-1:0]  ph_consume_dw_i,
  input  logic [HDR_W-1:0]  nph_consume_dw_i,
  input  logic [HDR_W-1:0]  cplh_consume_dw_i,
  input  logic              pd_consume_v_i,
  input  logic              npd_consume_v_i,
  input  logic              cpld_consume_v_i,
  input  logic [DATA_W-1:0] pd_consume_dw_i,
  input  logic [DATA_W-1:0] npd_consume_dw_i,
  input  logic [DATA_W-1:0] cpld_consume_dw_i,
  output logic              ph_credit_ok_o,
  output logic              pd_credit_ok_o,
  output logic              nph_credit_ok_o,
  output logic              npd_credit_ok_o,
  output logic              cplh_credit_ok_o,
  output logic              cpld_credit_ok_o,
  output logic              init_done_o,
  output logic              fc_err_o
);

  typedef enum logic [1:0] {StLinkDown, StInit, StActive} state_e;

  localparam logic [HDR_W-1:0]  HdrHalf  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DataHalf = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DataMin  = DATA_W'(MAX_PAYLOAD_CR);

  state_e                   state_q, state_d;
  logic [2:0][HDR_W-1:0]    hcl_q, hcl_d, hcc_q, hcc_d;
  logic [2:0][DATA_W-1:0]   dcl_q, dcl_d, dcc_q, dcc_d;
  logic [2:0]               got_q, got_d;
  logic [2:0]               hinf_q, hinf_d, dinf_q, dinf_d;
  logic                     fc_err_q, fc_err_d;

  // Pool index 0 = P, 1 = NP, 2 = Cpl, matching fc_type_i.
  logic [2:0]               hdr_cv, data_cv;
  logic [2:0][HDR_W-1:0]    hdr_cdw;
  logic [2:0][DATA_W-1:0]   data_cdw;
  logic [2:0][DATA_W:0]     data_sum;
  logic [2:0][HDR_W-1:0]    hdr_av;
  logic [2:0][DATA_W-1:0]   data_av;
  logic [2:0]               hdr_ok, data_ok;
  logic                     fc_legal, active;

  assign hdr_cv   = {cplh_consume_v_i, nph_consume_v_i, ph_consume_v_i};
  assign data_cv  = {cpld_consume_v_i, npd_consume_v_i, pd_consume_v_i};
  assign hdr_cdw  = {cplh_consume_dw_i, nph_consume_dw_i, ph_consume_dw_i};
  assign data_cdw = {cpld_consume_dw_i, npd_consume_dw_i, pd_consume_dw_i};
  assign fc_legal = fc_valid_i && (fc_type_i != 2'b11);
  assign active   = (state_q == StActive);

  always_comb begin
    state_d  = state_q;
    hcl_d    = hcl_q;
    hcc_d    = hcc_q;
    dcl_d    = dcl_q;
    dcc_d    = dcc_q;
    got_d    = got_q;
    hinf_d   = hinf_q;
    dinf_d   = dinf_q;
    fc_err_d = fc_valid_i && (fc_type_i == 2'b11);
    for (int i = 0; i < 3; i++) begin
      // Round DW up to 4-DW credits with one spare bit so dw near full scale cannot wrap.
      data_sum[i] = {1'b0, data_cdw[i]} + (DATA_W+1)'(3);
    end

    if (!link_up_i) begin
      state_d = StLinkDown;
      hcl_d   = '0;
      hcc_d   = '0;
      dcl_d   = '0;
      dcc_d   = '0;
      got_d   = '0;
      hinf_d  = '0;
      dinf_d  = '0;
    end else begin
      case (state_q)
        StLinkDown: state_d = StInit;
        StInit: begin
          if (fc_legal) begin
            if (fc_init_i) begin
              hcl_d[fc_type_i] = fc_hdr_i;
              dcl_d[fc_type_i] = fc_data_i;
              got_d[fc_type_i] = 1'b1;
`ifdef TL_CREDIT_INF_EN
              hinf_d[fc_type_i] = (fc_hdr_i == '0);
              dinf_d[fc_type_i] = (fc_data_i == '0);
`endif
            end else begin
              fc_err_d = 1'b1;
            end
          end
          if (&got_d) state_d = StActive;
        end
        StActive: begin
          if (fc_legal && !fc_init_i) begin
            if (!hinf_q[fc_type_i]) hcl_d[fc_type_i] = fc_hdr_i;
            if (!dinf_q[fc_type_i]) dcl_d[fc_type_i] = fc_data_i;
          end
          for (int i = 0; i < 3; i++) begin
            if (hdr_cv[i] && !hinf_q[i])  hcc_d[i] = hcc_q[i] + hdr_cdw[i];
            if (data_cv[i] && !dinf_q[i]) dcc_d[i] = dcc_q[i] + {1'b0, data_sum[i][DATA_W:2]};
          end
        end
        default: state_d = StLinkDown;
      endcase
    end
  end

  // Avail above half-range means CC has run past CL, so the pool is reported exhausted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hdr_av[i]  = hcl_q[i] - hcc_q[i];
      data_av[i] = dcl_q[i] - dcc_q[i];
      hdr_ok[i]  = active && (hinf_q[i] || ((hdr_av[i] != '0) && (hdr_av[i] <= HdrHalf)));
      data_ok[i] = active && (dinf_q[i] || ((data_av[i] >= DataMin) && (data_av[i] <= DataHalf)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLinkDown;
      hcl_q    <= '0;
      hcc_q    <= '0;
      dcl_q    <= '0;
      dcc_q    <= '0;
      got_q    <= '0;
      hinf_q   <= '0;
      dinf_q   <= '0;
      fc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcl_q    <= hcl_d;
      hcc_q    <= hcc_d;
      dcl_q    <= dcl_d;
      dcc_q    <= dcc_d;
      got_q    <= got_d;
      hinf_q   <= hinf_d;
      dinf_q   <= dinf_d;
      fc_err_q <= fc_err_d;
    end
  end

  assign ph_credit_ok_o   = hdr_ok[0];
  assign nph_credit_ok_o  = hdr_ok[1];
  assign cplh_credit_ok_o = hdr_ok[2];
  assign pd_credit_ok_o   = data_ok[0];
  assign npd_credit_ok_o  = data_ok[1];
  assign cpld_credit_ok_o = data_ok[2];
  assign init_done_o      = active;
  assign fc_err_o         = fc_err_q;

endmodule

// File: tb/tb_tl_tx_credit_ctrl.sv
// Bench for tl_tx_credit_ctrl: directed vector table, async-reset/relink sequence, and randomized
// traffic checked against an arithmetic credit model.
module tb_tl_tx_credit_ctrl;

  localparam int HMOD = 256;
  localparam int DMOD = 4096;
`ifdef TL_CREDIT_INF_EN
  localparam logic [7:0] NI = 8'h10;
`else
  localparam logic [7:0] NI = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        link_up, fc_valid, fc_init;
  logic [1:0]  fc_type;
  logic [7:0]  fc_hdr;
  logic [11:0] fc_data;
  logic        ph_v, nph_v, cplh_v, pd_v, npd_v, cpld_v;
  logic [7:0]  ph_dw, nph_dw, cplh_dw;
  logic [11:0] pd_dw, npd_dw, cpld_dw;
  logic        ph_ok, pd_ok, nph_ok, npd_ok, cplh_ok, cpld_ok, init_done, fc_err;
  logic [7:0]  dut_out;

  assign dut_out = {ph_ok, pd_ok, nph_ok, npd_ok, cplh_ok, cpld_ok, init_done, fc_err};

  tl_tx_credit_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .link_up_i        (link_up),
    .fc_valid_i       (fc_valid),
    .fc_init_i        (fc_init),
    .fc_type_i        (fc_type),
    .fc_hdr_i         (fc_hdr),
    .fc_data_i        (fc_data),
    .ph_consume_v_i   (ph_v),
    .nph_consume_v_i  (nph_v),
    .cplh_consume_v_i (cplh_v),
    .ph_consume_dw_i  (ph_dw),
    .nph_consume_dw_i (nph_dw),
    .cplh_consume_dw_i(cplh_dw),
    .pd_consume_v_i   (pd_v),
    .npd_consume_v_i  (npd_v),
    .cpld_consume_v_i (cpld_v),
    .pd_consume_dw_i  (pd_dw),
    .npd_consume_dw_i (npd_dw),
    .cpld_consume_dw_i(cpld_dw),
    .ph_credit_ok_o   (ph_ok),
    .pd_credit_ok_o   (pd_ok),
    .nph_credit_ok_o  (nph_ok),
    .npd_credit_ok_o  (npd_ok),
    .cplh_credit_ok_o (cplh_ok),
    .cpld_credit_ok_o (cpld_ok),
    .init_done_o      (init_done),
    .fc_err_o         (fc_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs %b, expected %b (ok ph pd nph npd cplh cpld, done, err)",
               name, got, exp);
    end
  endtask

  // Reference model: link phase (0 down, 1 init, 2 active) and per-pool limit/consumed integers.
  int m_phase;
  int m_hcl[3], m_hcc[3], m_dcl[3], m_dcc[3];
  bit m_got[3], m_hinf[3], m_dinf[3];
  bit m_err;

  task automatic model_reset();
    m_phase = 0;
    m_err   = 0;
    for (int i = 0; i < 3; i++) begin
      m_hcl[i] = 0; m_hcc[i] = 0; m_dcl[i] = 0; m_dcc[i] = 0;
      m_got[i] = 0; m_hinf[i] = 0; m_dinf[i] = 0;
    end
  endtask

  task automatic model_step();
    int t;
    bit hv[3], dv[3];
    int hd[3], dd[3];
    bit err_n;
    t  = int'(fc_type);
    hv = '{ph_v, nph_v, cplh_v};
    dv = '{pd_v, npd_v, cpld_v};
    hd = '{int'(ph_dw), int'(nph_dw), int'(cplh_dw)};
    dd = '{int'(pd_dw), int'(npd_dw), int'(cpld_dw)};
    err_n = fc_valid && (t == 3);
    if (!link_up) begin
      model_reset();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (fc_valid && t != 3) begin
        if (fc_init) begin
          m_hcl[t] = int'(fc_hdr);
          m_dcl[t] = int'(fc_data);
          m_got[t] = 1;
`ifdef TL_CREDIT_INF_EN
          m_hinf[t] = (fc_hdr == 8'd0);
          m_dinf[t] = (fc_data == 12'd0);
`endif
        end else begin
          err_n = 1;
        end
      end
      if (m_got[0] && m_got[1] && m_got[2]) m_phase = 2;
    end else begin
      if (fc_valid && t != 3 && !fc_init) begin
        if (!m_hinf[t]) m_hcl[t] = int'(fc_hdr);
        if (!m_dinf[t]) m_dcl[t] = int'(fc_data);
      end
      for (int i = 0; i < 3; i++) begin
        if (hv[i] && !m_hinf[i]) m_hcc[i] = (m_hcc[i] + hd[i]) % HMOD;
        if (dv[i] && !m_dinf[i]) m_dcc[i] = (m_dcc[i] + (dd[i] + 3) / 4) % DMOD;
      end
    end
    m_err = err_n;
  endtask

  function automatic logic [7:0] model_out();
    bit hok[3], dok[3];
    int ha, da;
    for (int i = 0; i < 3; i++) begin
      ha = ((m_hcl[i] - m_hcc[i]) % HMOD + HMOD) % HMOD;
      da = ((m_dcl[i] - m_dcc[i]) % DMOD + DMOD) % DMOD;
      hok[i] = (m_phase == 2) && (m_hinf[i] || (ha >= 1 && ha <= HMOD / 2));
      dok[i] = (m_phase == 2) && (m_dinf[i] || (da >= 64 && da <= DMOD / 2));
    end
    return {hok[0], dok[0], hok[1], dok[1], hok[2], dok[2], m_phase == 2, m_err};
  endfunction

  task automatic clear_in();
    fc_valid = 0; fc_init = 0; fc_type = 2'd0; fc_hdr = 8'd0; fc_data = 12'd0;
    ph_v = 0; nph_v = 0; cplh_v = 0; pd_v = 0; npd_v = 0; cpld_v = 0;
    ph_dw = 8'd0; nph_dw = 8'd0; cplh_dw = 8'd0;
    pd_dw = 12'd0; npd_dw = 12'd0; cpld_dw = 12'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out, model_out());
  endtask

  typedef struct {
    logic        lu, v, ini;
    logic [1:0]  typ;
    logic [7:0]  hdr;
    logic [11:0] data;
    logic        phv;
    logic [7:0]  phdw;
    logic        pdv;
    logic [11:0] pddw;
    logic [7:0]  exp;
  } vec_t;

  function automatic vec_t mk(logic lu, logic v, logic ini, logic [1:0] typ, logic [7:0] hdr,
                              logic [11:0] data, logic phv, logic [7:0] phdw, logic pdv,
                              logic [11:0] pddw, logic [7:0] exp);
    vec_t r;
    r.lu = lu; r.v = v; r.ini = ini; r.typ = typ; r.hdr = hdr; r.data = data;
    r.phv = phv; r.phdw = phdw; r.pdv = pdv; r.pddw = pddw; r.exp = exp;
    return r;
  endfunction

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 8'd32,  12'd128, 1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 2'd1, 8'd16,  12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 2'd2, 8'd32,  12'd256, 1'b0, 8'd0,   1'b0, 12'd0,   8'hEE | NI);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b1, 12'd256, 8'hEE | NI);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b1, 12'd1,   8'hAE | NI);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'd32,  12'd200, 1'b0, 8'd0,   1'b0, 12'd0,   8'hEE | NI);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'd5,   12'd200, 1'b1, 8'd250, 1'b0, 12'd0,   8'hEE | NI);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b1, 8'd12,  1'b0, 12'd0,   8'h6E | NI);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 2'd3, 8'd100, 12'd100, 1'b0, 8'd0,   1'b0, 12'd0,   8'h6F | NI);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h6E | NI);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'd5,   12'd201, 1'b0, 8'd0,   1'b1, 12'd4,   8'h6E | NI);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b1, 12'd400, 8'h00);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[15] = mk(1'b1, 1'b1, 1'b1, 2'd0, 8'd32,  12'd128, 1'b0, 8'd0,   1'b1, 12'd400, 8'h00);
    tbl[16] = mk(1'b1, 1'b1, 1'b1, 2'd1, 8'd16,  12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h00);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'h01);
    tbl[18] = mk(1'b1, 1'b1, 1'b1, 2'd2, 8'd32,  12'd256, 1'b0, 8'd0,   1'b0, 12'd0,   8'hEE | NI);
    tbl[19] = mk(1'b1, 1'b1, 1'b1, 2'd0, 8'd0,   12'd0,   1'b0, 8'd0,   1'b0, 12'd0,   8'hEE | NI);

    link_up = 0;
    clear_in();
    model_reset();
    #12;
    check("reset_state", dut_out, 8'h00);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      clear_in();
      link_up  = tbl[i].lu;
      fc_valid = tbl[i].v;
      fc_init  = tbl[i].ini;
      fc_type  = tbl[i].typ;
      fc_hdr   = tbl[i].hdr;
      fc_data  = tbl[i].data;
      ph_v     = tbl[i].phv;
      ph_dw    = tbl[i].phdw;
      pd_v     = tbl[i].pdv;
      pd_dw    = tbl[i].pddw;
      tick();
      check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
    end

    // Asynchronous reset in ACTIVE, then a relink that must see all three InitFCs again.
    clear_in();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_reset", dut_out, 8'h00);
    @(negedge clk);
    rst_n = 1;
    tick();
    fc_valid = 1; fc_init = 1; fc_type = 2'd0; fc_hdr = 8'd40; fc_data = 12'd300;
    tick();
    fc_type = 2'd1; fc_hdr = 8'd20; fc_data = 12'd100;
    tick();
    check("relink_partial_init", dut_out, 8'h00);
    fc_type = 2'd2; fc_hdr = 8'd10; fc_data = 12'd64;
    tick();
    check("relink_complete", dut_out, 8'hFE);
    clear_in();

    for (int n = 0; n < 3000; n++) begin
      link_up  = ($urandom_range(0, 79) != 0);
      fc_valid = ($urandom_range(0, 2) == 0);
      fc_init  = ($urandom_range(0, 1) == 0);
      fc_type  = 2'($urandom_range(0, 3));
      fc_hdr   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      fc_data  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(0, 4095));
      ph_v     = $urandom_range(0, 1) == 1;
      nph_v    = $urandom_range(0, 1) == 1;
      cplh_v   = $urandom_range(0, 1) == 1;
      pd_v     = $urandom_range(0, 1) == 1;
      npd_v    = $urandom_range(0, 1) == 1;
      cpld_v   = $urandom_range(0, 1) == 1;
      ph_dw    = 8'($urandom_range(0, 40));
      nph_dw   = 8'($urandom_range(0, 40));
      cplh_dw  = 8'($urandom_range(0, 40));
      pd_dw    = 12'($urandom_range(0, 600));
      npd_dw   = 12'($urandom_range(0, 600));
      cpld_dw  = ($urandom_range(0, 15) == 0) ? 12'd4095 : 12'($urandom_range(0, 600));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_tx_credit_ctrl.md
Name: tl_tx_credit_ctrl

Overview:
Transmit-side flow-control credit controller for the transaction layer. It tracks the credit limit (CL) advertised by the link partner and the credits consumed (CC) for six pools: PH, PD, NPH, NPD, CPLH and CPLD. From these it drives the per-pool credit_ok flags and accepts the consume pulses issued by the TX arbiter. It sits between the DLLP receive path, which supplies InitFC/UpdateFC values, and the TX arbiter.

Parameters:
HDR_W, 8, width of the header pools (PH/NPH/CPLH CL, CC and consume fields)
DATA_W, 12, width of the data pools (PD/NPD/CPLD CL and CC, in 4-DW credit units) and of the data consume field
MAX_PAYLOAD_CR, 64, minimum data credits (16 B each) required before a data pool reports ok

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
link_up_i  in  1  data-link layer up
fc_valid_i  in  1  flow-control DLLP value valid (one-cycle pulse)
fc_init_i  in  1  1 = InitFC, 0 = UpdateFC
fc_type_i  in  2  00 = P, 01 = NP, 10 = Cpl, 11 = illegal
fc_hdr_i  in  HDR_W  header credit value
fc_data_i  in  DATA_W  data credit value
ph_consume_v_i / nph_consume_v_i / cplh_consume_v_i  in  1 each  header consume strobes
ph_consume_dw_i / nph_consume_dw_i / cplh_consume_dw_i  in  HDR_W each  header credits to consume
pd_consume_v_i / npd_consume_v_i / cpld_consume_v_i  in  1 each  data consume strobes
pd_consume_dw_i / npd_consume_dw_i / cpld_consume_dw_i  in  DATA_W each  payload length in DW
ph/pd/nph/npd/cplh/cpld_credit_ok_o  out  1 each  pool has sufficient credit
init_done_o  out  1  controller is in ACTIVE
fc_err_o  out  1  one-cycle protocol error pulse

Behaviour:
- Reset: state is LINK_DOWN. All CL and CC registers are 0. All credit_ok_o, init_done_o and fc_err_o are 0.
- State machine: LINK_DOWN -> INIT -> ACTIVE.
  - link_up_i = 0 in any state: the next state is LINK_DOWN, and all CL, CC and got bits clear.
  - LINK_DOWN -> INIT when link_up_i = 1.
- INIT:
  - InitFC latches CL_hdr/CL_data for fc_type_i and sets got[type]. A repeat InitFC of the same type overwrites the values.
  - The state moves to ACTIVE on the edge after got = 3'b111. This includes the case where the last InitFC arrives in the current cycle.
  - An UpdateFC received in INIT is dropped and pulses fc_err_o.
- ACTIVE:
  - UpdateFC writes CL absolutely (not incrementally) for both the header and data pools of its type.
  - InitFC is ignored silently.
- In any state, fc_type_i = 11 with fc_valid_i drops the DLLP and pulses fc_err_o.
- fc_err_o is registered and asserts on the edge after the offending input.
- Consume (honoured only in ACTIVE; otherwise ignored):
  - Header pools: CC += consume_dw, mod 2^HDR_W.
  - Data pools: CC += (dw + 3) >> 2, computed at DATA_W+1 bits and truncated mod 2^DATA_W.
- A consume and an UpdateFC to the same pool in the same cycle both take effect.
- avail = (CL - CC) mod 2^W.
- hdr ok = ACTIVE && 1 <= avail <= 2^(HDR_W-1).
- data ok = ACTIVE && MAX_PAYLOAD_CR <= avail <= 2^(DATA_W-1).
  - avail above the half-range means CC has overrun CL, and the pool reports not ok.
- ok outputs are combinational from registered state, CL and CC. A consume or update sampled at edge N is reflected after edge N.
- init_done_o = (state == ACTIVE).
- Reset asserted mid-operation clears everything asynchronously. After release the controller returns to LINK_DOWN and requires a fresh InitFC for all three types.

Optional Feature:
TL_CREDIT_INF_EN:
- Defined: an InitFC field value of 0 marks that pool infinite. Its ok is 1 whenever ACTIVE, consumes are ignored, and UpdateFC to it is ignored. The infinite flag clears in LINK_DOWN.
- Undefined: 0 is a literal credit limit, and the pool stays not ok until an UpdateFC raises CL.

Test Plan:
1. Reset, then link_up=1 with InitFC P(hdr=32, data=128), NP(16, 0), Cpl(32, 256):
   - init_done=1 the cycle after the third InitFC.
   - ph_ok=1, pd_ok=1, nph_ok=1, npd_ok=0, cplh_ok=1, cpld_ok=1.
   - With TL_CREDIT_INF_EN defined, npd_ok=1.
2. ACTIVE with PD CL=128: pd_consume dw=256 (64 credits) -> pd_ok stays 1; a second dw=1 (1 credit) -> avail=63 and pd_ok=0.
   - UpdateFC P data=200 -> pd_ok=1 the next cycle.
3. PH CL=5 and CC=250: avail wraps to 11 -> ph_ok=1. Consume 12 more -> avail=255 (>128) -> ph_ok=0.
4. UpdateFC during INIT -> fc_err_o one-cycle pulse, CL unchanged. fc_type=11 in ACTIVE -> fc_err_o pulse, no pool changes.
5. Simultaneous pd_consume dw=4 and UpdateFC P data=CL+1 in the same cycle -> net PD avail unchanged the next cycle.
6. link_up drops in ACTIVE -> all ok=0 and init_done=0 the next cycle. Re-link requires all three InitFC. A consume while not ACTIVE leaves CC=0.
